// File: rtl/snpu_host_seq.sv
// Host-side sequencer: expands high-level game requests into SNPU command bytes,
// collects the responses and reports one result pulse per request.
module snpu_host_seq #(
  parameter int SHUF_ROUNDS = 4,
  parameter int TIMEOUT     = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_kind,
  input  logic [4:0] req_arg,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [7:0] cmd_data,
  input  logic       rsp_valid,
  input  logic [7:0] rsp_data,
  output logic       result_valid,
  output logic [7:0] result_data,
  output logic       result_err,
  output logic       busy
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_ERR} state_t;

  localparam logic [1:0] K_NEW_GAME  = 2'd0;
  localparam logic [1:0] K_LEGISLATE = 2'd1;
  localparam logic [1:0] K_PEEK      = 2'd2;

  state_t      state_reg, state_next;
  logic [1:0]  kind_reg;
  logic [4:0]  arg_reg;
  logic [4:0]  step_reg, step_next;
  logic [7:0]  timer_reg, timer_next;
  logic [1:0]  bits_reg;
  logic [7:0]  result_reg;
  logic [7:0]  cmd_byte;
  logic [4:0]  n_cmds;
  logic        last_cmd;
  logic        req_ok;
  logic [7:0]  done_value;

  always_comb begin
    req_ok = 1'b1;
    if (req_kind == K_NEW_GAME)
      req_ok = (req_arg >= 5'd5) && (req_arg <= 5'd10);
    else if (req_kind == K_LEGISLATE)
      req_ok = (req_arg[1:0] != 2'd3);
  end

  // Command byte for the current step of the latched request.
  always_comb begin
    cmd_byte = 8'hE0;
    n_cmds   = 5'd1;
    case (kind_reg)
      K_NEW_GAME: begin
        n_cmds = 5'(SHUF_ROUNDS + 2);
        if (step_reg == 5'd0)      cmd_byte = 8'h00;
        else if (step_reg == 5'd1) cmd_byte = {3'b001, arg_reg};
        else                       cmd_byte = {3'b011, 5'd0};
      end
      K_LEGISLATE: begin
        n_cmds = 5'd6;
        case (step_reg)
          5'd0, 5'd1, 5'd2: cmd_byte = {3'b100, step_reg};
          5'd3:             cmd_byte = {3'b101, 3'd0, arg_reg[1:0]};
          5'd4:             cmd_byte = {3'b110, 4'd0, arg_reg[2]};
          default:          cmd_byte = {3'b111, 5'd0};
        endcase
      end
      K_PEEK: begin
        n_cmds   = 5'd3;
        cmd_byte = {3'b100, step_reg};
      end
      default: begin
        n_cmds   = 5'd1;
        cmd_byte = {3'b111, 5'd0};
      end
    endcase
  end

  assign last_cmd = (step_reg == n_cmds - 5'd1);

  always_comb begin
    case (kind_reg)
      K_NEW_GAME: done_value = 8'h00;
      K_PEEK:     done_value = {5'd0, bits_reg, rsp_data[0]};
      default:    done_value = rsp_data;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    step_next  = step_reg;
    timer_next = timer_reg;
    case (state_reg)
      S_IDLE: begin
        if (req_valid) begin
          state_next = req_ok ? S_ISSUE : S_ERR;
          step_next  = 5'd0;
        end
      end
      S_ISSUE: begin
        if (cmd_ready) begin
          state_next = S_WAIT;
          timer_next = 8'd0;
        end
      end
      S_WAIT: begin
        // A response arriving on the final allowed cycle still counts.
        if (rsp_valid) begin
          state_next = last_cmd ? S_DONE : S_ISSUE;
          step_next  = step_reg + 5'd1;
        end else if (timer_reg == 8'(TIMEOUT - 1)) begin
          state_next = S_ERR;
        end else begin
          timer_next = timer_reg + 8'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      kind_reg   <= 2'd0;
      arg_reg    <= 5'd0;
      step_reg   <= 5'd0;
      timer_reg  <= 8'd0;
      bits_reg   <= 2'd0;
      result_reg <= 8'd0;
    end else begin
      state_reg <= state_next;
      step_reg  <= step_next;
      timer_reg <= timer_next;
      if (state_reg == S_IDLE && req_valid) begin
        kind_reg <= req_kind;
        arg_reg  <= req_arg;
      end
      if (state_reg == S_WAIT && rsp_valid)
        bits_reg <= {bits_reg[0], rsp_data[0]};
      if (state_next == S_ERR)
        result_reg <= 8'd0;
      else if (state_reg == S_WAIT && state_next == S_DONE)
        result_reg <= done_value;
    end
  end

  assign req_ready    = (state_reg == S_IDLE);
  assign busy         = (state_reg != S_IDLE);
  assign cmd_valid    = (state_reg == S_ISSUE);
  assign cmd_data     = (state_reg == S_ISSUE) ? cmd_byte : 8'h00;
  assign result_valid = (state_reg == S_DONE) || (state_reg == S_ERR);
  assign result_err   = (state_reg == S_ERR);
  assign result_data  = result_reg;

endmodule

// File: tb/tb_snpu_host_seq.sv
// Randomized bench for snpu_host_seq: a request-level model predicts the command
// stream and result of each request; an SNPU responder with random timing drives it.
module tb_snpu_host_seq;
  localparam int SR = 4;
  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_kind = 2'd0;
  logic [4:0] req_arg = 5'd0;
  logic       cmd_valid;
  logic       cmd_ready = 1'b0;
  logic [7:0] cmd_data;
  logic       rsp_valid = 1'b0;
  logic [7:0] rsp_data = 8'd0;
  logic       result_valid;
  logic [7:0] result_data;
  logic       result_err;
  logic       busy;

  snpu_host_seq #(.SHUF_ROUNDS(SR), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind), .req_arg(req_arg),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .result_valid(result_valid), .result_data(result_data), .result_err(result_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rsp_fix[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic bit arg_ok(input int kind, input int arg);
    if (kind == 0) return (arg >= 5) && (arg <= 10);
    if (kind == 1) return (arg % 4) != 3;
    return 1'b1;
  endfunction

  // Expected command list: each byte is op*32 + arg.
  task automatic build(input int kind, input int arg);
    exp_q.delete();
    case (kind)
      0: begin
        exp_q.push_back(8'(0));
        exp_q.push_back(8'(32 + arg));
        for (int i = 0; i < SR; i++) exp_q.push_back(8'(3 * 32));
      end
      1: begin
        for (int i = 0; i < 3; i++) exp_q.push_back(8'(4 * 32 + i));
        exp_q.push_back(8'(5 * 32 + arg % 4));
        exp_q.push_back(8'(6 * 32 + (arg / 4) % 2));
        exp_q.push_back(8'(7 * 32));
      end
      2: for (int i = 0; i < 3; i++) exp_q.push_back(8'(4 * 32 + i));
      default: exp_q.push_back(8'(7 * 32));
    endcase
  endtask

  task automatic run_req(input int kind, input int arg, input int rdy_low, input int dly,
                         input int to_idx, input int abort_idx);
    logic [7:0] last_rsp;
    logic [7:0] r;
    int peek;
    int cnt;
    int d;
    bit hs;
    logic [7:0] exp_res;
    last_rsp = 8'd0;
    peek = 0;
    chk("idle_ready", 32'(req_ready), 1);
    chk("idle_busy", 32'(busy), 0);
    build(kind, arg);
    req_valid = 1'b1;
    req_kind  = 2'(kind);
    req_arg   = 5'(arg);
    step();
    req_valid = 1'b0;
    req_kind  = 2'($urandom);
    req_arg   = 5'($urandom);
    if (!arg_ok(kind, arg)) begin
      chk("inv_rv", 32'(result_valid), 1);
      chk("inv_err", 32'(result_err), 1);
      chk("inv_data", 32'(result_data), 0);
      chk("inv_cmdv", 32'(cmd_valid), 0);
      step();
      chk("inv_end", 32'(result_valid), 0);
      chk("inv_cmdv2", 32'(cmd_valid), 0);
      $display("req kind=%0d arg=%0d -> rejected", kind, arg);
      return;
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      chk("cmd_valid", 32'(cmd_valid), 1);
      chk("cmd_data", 32'(cmd_data), 32'(exp_q[i]));
      chk("busy", 32'(busy), 1);
      hs = 1'b0;
      cnt = 0;
      while (!hs) begin
        if (cnt > 0) begin
          chk("cmd_hold_v", 32'(cmd_valid), 1);
          chk("cmd_hold_d", 32'(cmd_data), 32'(exp_q[i]));
        end
        cmd_ready = (i == 0 && cnt < rdy_low) ? 1'b0 : ($urandom_range(0, 2) != 0);
        hs = cmd_ready && cmd_valid;
        step();
        cnt++;
        if (!hs && cnt > 60) begin
          chk("hs_bound", 0, 1);
          cmd_ready = 1'b0;
          return;
        end
      end
      cmd_ready = 1'b0;
      chk("wait_cmdv", 32'(cmd_valid), 0);
      if (i == abort_idx) begin
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_cmdv", 32'(cmd_valid), 0);
        chk("abort_ready", 32'(req_ready), 1);
        chk("abort_rv", 32'(result_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
          step();
          chk("abort_nores", 32'(result_valid), 0);
        end
        $display("req kind=%0d arg=%0d -> aborted by reset at cmd %0d", kind, arg, i);
        return;
      end
      if (i == to_idx) begin
        cnt = 0;
        while (!result_valid && cnt < TO + 20) begin
          step();
          cnt++;
        end
        chk("to_cycles", 32'(cnt), 32'(TO));
        chk("to_err", 32'(result_err), 1);
        chk("to_data", 32'(result_data), 0);
        step();
        chk("to_end", 32'(result_valid), 0);
        $display("req kind=%0d arg=%0d -> timeout at cmd %0d", kind, arg, i);
        return;
      end
      d = (dly != 0) ? dly : $urandom_range(1, TO);
      repeat (d - 1) begin
        step();
        chk("wait_nores", 32'(result_valid), 0);
      end
      r = (rsp_fix.size() != 0) ? rsp_fix.pop_front() : 8'($urandom);
      rsp_valid = 1'b1;
      rsp_data  = r;
      step();
      rsp_valid = 1'b0;
      rsp_data  = 8'($urandom);
      last_rsp = r;
      if (i < 3) peek = peek * 2 + int'(r[0]);
    end
    if (kind == 0)      exp_res = 8'd0;
    else if (kind == 2) exp_res = 8'(peek);
    else                exp_res = last_rsp;
    chk("done_rv", 32'(result_valid), 1);
    chk("done_err", 32'(result_err), 0);
    chk("done_data", 32'(result_data), 32'(exp_res));
    step();
    chk("done_end", 32'(result_valid), 0);
    chk("res_hold", 32'(result_data), 32'(exp_res));
    $display("req kind=%0d arg=%0d -> result=0x%02h", kind, arg, result_data);
  endtask

  initial begin
    int k;
    int a;
    #3;
    chk("rst_cmdv", 32'(cmd_valid), 0);
    chk("rst_cmdd", 32'(cmd_data), 0);
    chk("rst_rv", 32'(result_valid), 0);
    chk("rst_err", 32'(result_err), 0);
    chk("rst_data", 32'(result_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(req_ready), 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    run_req(0, 7, 0, 2, -1, -1);
    rsp_fix = '{8'h01, 8'h00, 8'h01};
    run_req(2, 0, 0, 0, -1, -1);
    rsp_fix = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h21};
    run_req(1, 6, 0, 0, -1, -1);
    run_req(3, 0, 5, 0, 0, -1);
    run_req(0, 4, 0, 0, -1, -1);
    run_req(1, 3, 0, 0, -1, -1);
    run_req(0, 11, 0, 0, -1, -1);
    run_req(0, 5, 0, 1, -1, -1);
    run_req(0, 10, 0, TO, -1, -1);
    run_req(1, 5, 0, 0, -1, 2);
    run_req(3, 0, 0, 0, -1, -1);

    for (int n = 0; n < 30; n++) begin
      k = $urandom_range(0, 3);
      a = $urandom_range(0, 31);
      if (k == 0 && $urandom_range(0, 2) != 0) a = $urandom_range(5, 10);
      run_req(k, a, $urandom_range(0, 3), 0,
              ($urandom_range(0, 5) == 0) ? $urandom_range(0, 2) : -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
